// File: rtl/i2s_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : i2s_encoder
//  Purpose  : I2S master transmitter (Philips format). Serialises stereo PCM
//             sample pairs MSB first onto SCK/WS/SD, with one SCK of delay
//             after every WS edge. SCK and WS are derived from sys_clk. One
//             pair waits in a holding buffer while another is being shifted.
//  Ports    : sys_clk, sys_rst          - clock, synchronous active-high reset
//             s_valid/s_ready           - sample pair handshake
//             s_l_data/s_r_data         - left/right samples (two's complement)
//             o_sck/o_ws/o_sd           - I2S bit clock, word select, data
//             frame_start               - pulse on the first tick of a frame
//             underrun                  - pulse when a frame starts empty
//  Revision : 1.0 - initial release
// ============================================================================
module i2s_encoder #(
  parameter int DATAWIDTH = 24,
  parameter int SLOT_BITS = 32,
  parameter int SCLK_DIV  = 9
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATAWIDTH-1:0] s_l_data,
  input  logic [DATAWIDTH-1:0] s_r_data,
  output logic                 o_sck,
  output logic                 o_ws,
  output logic                 o_sd,
  output logic                 frame_start,
  output logic                 underrun
);

  localparam int c_frame_bits = 2 * SLOT_BITS;
  localparam int c_bw         = $clog2(c_frame_bits);
  localparam int c_dw         = $clog2(SCLK_DIV);

  localparam logic [c_dw-1:0] c_div_last = c_dw'(SCLK_DIV - 1);
  localparam logic [c_dw-1:0] c_div_one  = c_dw'(1);
  localparam logic [c_dw-1:0] c_sck_hi   = c_dw'(SCLK_DIV - SCLK_DIV / 2);
  localparam logic [c_bw-1:0] c_bit_last = c_bw'(c_frame_bits - 1);
  localparam logic [c_bw-1:0] c_bit_one  = c_bw'(1);
  localparam logic [c_bw-1:0] c_slot     = c_bw'(SLOT_BITS);
  localparam logic [c_bw-1:0] c_dwidth   = c_bw'(DATAWIDTH);

  logic [c_dw-1:0]      r_div_cnt;
  logic [c_bw-1:0]      r_bit_cnt;
  logic                 r_buf_empty;
  logic [DATAWIDTH-1:0] r_buf_l;
  logic [DATAWIDTH-1:0] r_buf_r;
  logic [DATAWIDTH-1:0] r_sh_l;
  logic [DATAWIDTH-1:0] r_sh_r;

  logic            w_tick;
  logic [c_dw-1:0] w_div_nxt;
  logic [c_bw-1:0] w_bit_nxt;
  logic            w_ws_nxt;
  logic [c_bw-1:0] w_p_nxt;
  logic            w_data_bit;
  logic            w_fs;
  logic            w_xfer;

  // The tick is the SCK falling edge; everything serial changes only here.
  assign w_tick     = (r_div_cnt == c_div_last);
  assign w_div_nxt  = w_tick ? '0 : r_div_cnt + c_div_one;
  assign w_bit_nxt  = (r_bit_cnt == c_bit_last) ? '0 : r_bit_cnt + c_bit_one;
  assign w_ws_nxt   = (w_bit_nxt >= c_slot);
  assign w_p_nxt    = w_ws_nxt ? (w_bit_nxt - c_slot) : w_bit_nxt;
  // p=0 is the one-SCK delay slot after WS changes; data runs p=1..DATAWIDTH.
  assign w_data_bit = (w_p_nxt != '0) && (w_p_nxt <= c_dwidth);
  assign w_fs       = w_tick && (w_bit_nxt == '0);
  assign w_xfer     = s_valid && r_buf_empty;

  assign s_ready    = r_buf_empty;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_div_cnt   <= '0;
      r_bit_cnt   <= c_bit_last;
      r_buf_empty <= 1'b1;
      r_buf_l     <= '0;
      r_buf_r     <= '0;
      r_sh_l      <= '0;
      r_sh_r      <= '0;
      o_sck       <= 1'b0;
      o_ws        <= 1'b0;
      o_sd        <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      r_div_cnt   <= w_div_nxt;
      // SCK is registered from the next divider value so it lines up with
      // the counter phase seen in the same cycle.
      o_sck       <= (w_div_nxt >= c_sck_hi);
      frame_start <= w_fs;
      underrun    <= w_fs && r_buf_empty;

      if (w_tick) begin
        r_bit_cnt <= w_bit_nxt;
        o_ws      <= w_ws_nxt;
        if (w_fs) begin
          o_sd <= 1'b0;
          if (!r_buf_empty) begin
            r_sh_l      <= r_buf_l;
            r_sh_r      <= r_buf_r;
            r_buf_empty <= 1'b1;
          end else begin
            r_sh_l <= '0;
            r_sh_r <= '0;
          end
        end else if (w_data_bit) begin
          if (w_ws_nxt) begin
            o_sd   <= r_sh_r[DATAWIDTH-1];
            r_sh_r <= r_sh_r << 1;
          end else begin
            o_sd   <= r_sh_l[DATAWIDTH-1];
            r_sh_l <= r_sh_l << 1;
          end
        end else begin
          o_sd <= 1'b0;
        end
      end

      // A transfer needs an empty buffer, so it never collides with the
      // frame-start drain above; an empty-buffer frame start still underruns.
      if (w_xfer) begin
        r_buf_l     <= s_l_data;
        r_buf_r     <= s_r_data;
        r_buf_empty <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
